// File: rtl/axis_sink_pkg.sv
// Shared types and constants for the random AXI-Stream sink.
package axis_sink_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    STALL  = 2'd2
  } sink_state_t;

  // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1 (maximal length).
  localparam logic [31:0] LFSR32_POLY = 32'h8020_0003;

  // Saturation point of the 16-bit pattern error counter.
  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/axis_lfsr32.sv
// 32-bit Galois LFSR with a seedable reset value; a zero seed becomes 1 so the
// register can never lock up in the all-zero state.
module axis_lfsr32
  import axis_sink_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;
  logic [31:0] seed_nz;

  assign seed_nz = (seed == 32'd0) ? 32'd1 : seed;
  assign state   = state_q;

  // Next value: shift right, fold the polynomial in when a one falls out.
  always_comb begin
    state_d = state_q;
    if (advance)
      state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR32_POLY : 32'd0);
  end

  // Reset reloads the seed so every run after reset is bit-identical.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= seed_nz;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/axis_random_sink.sv
// AXI-Stream receiver with seeded pseudo-random backpressure, an
// incrementing-data checker, and beat/packet/error counters.
module axis_random_sink
  import axis_sink_pkg::*;
#(
  parameter int          DATA_WIDTH                        = 32,
  parameter logic [31:0] RAND_SEED                         = 32'd3393937,
  parameter int          MAX_INTERRUPTIONS                 = 3,
  parameter int          RX_MAX_DELAY_BETWEEN_TRANSACTIONS = 42,
  parameter int          CHECK_PATTERN                     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] expected_first,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [31:0]           beat_count,
  output logic [31:0]           packet_count,
  output logic [15:0]           error_count,
  output logic                  error_flag
);

  localparam bit STALL_EN = (MAX_INTERRUPTIONS > 0) && (RX_MAX_DELAY_BETWEEN_TRANSACTIONS > 0);
  localparam int DLY_MOD  = (RX_MAX_DELAY_BETWEEN_TRANSACTIONS > 0) ? RX_MAX_DELAY_BETWEEN_TRANSACTIONS : 1;
  localparam logic [31:0] MAX_EP = 32'(MAX_INTERRUPTIONS);

  sink_state_t           state_q, state_d;
  logic [31:0]           ep_q, ep_d;
  logic [31:0]           stall_q, stall_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [31:0]           beat_q, beat_d;
  logic [31:0]           pkt_q, pkt_d;
  logic [15:0]           err_q, err_d;
  logic                  flag_q, flag_d;
  logic                  tready_q, tready_d;

  logic [31:0] lfsr;
  logic        hs, stall_take;
  logic [31:0] stall_len;
  logic        unused_lfsr;

  axis_lfsr32 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed    (RAND_SEED),
    .advance (state_q != IDLE),
    .state   (lfsr)
  );

  assign unused_lfsr = ^{lfsr[31:16], lfsr[7:2]};

  assign hs         = s_axis_tvalid & tready_q;
  assign stall_len  = 32'd1 + (32'(lfsr[15:8]) % 32'(DLY_MOD));
  assign stall_take = STALL_EN && (state_q == ACCEPT) && hs &&
                      (lfsr[1:0] == 2'b11) && (ep_q < MAX_EP);

  // FSM next state; a falling enable overrides any transition, including a stall.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACCEPT;
      ACCEPT:  if (stall_take) begin
                 state_d = STALL;
                 stall_d = stall_len;
               end
      STALL:   if (stall_q <= 32'd1) begin
                 state_d = ACCEPT;
                 stall_d = 32'd0;
               end else begin
                 stall_d = stall_q - 32'd1;
               end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
    tready_d = (state_d == ACCEPT);
  end

  // Episode count; a tlast clear lands after the stall decision of the same beat.
  always_comb begin
    ep_d = ep_q;
    if (stall_take) ep_d = ep_q + 32'd1;
    if (hs && s_axis_tlast) ep_d = stall_take ? 32'd1 : 32'd0;
  end

  // Pattern checker and counters; expected resyncs to tdata+1 after every beat.
  always_comb begin
    expected_d = expected_q;
    err_d      = err_q;
    flag_d     = flag_q;
    beat_d     = beat_q;
    pkt_d      = pkt_q;
    if (state_q == IDLE) expected_d = expected_first;
    if (hs) begin
      beat_d = beat_q + 32'd1;
      if (s_axis_tlast) pkt_d = pkt_q + 32'd1;
      if (CHECK_PATTERN != 0) begin
        if (s_axis_tdata != expected_q) begin
          if (err_q != ERR_CNT_MAX) err_d = err_q + 16'd1;
          flag_d = 1'b1;
        end
        expected_d = s_axis_tdata + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ep_q       <= 32'd0;
      stall_q    <= 32'd0;
      expected_q <= '0;
      beat_q     <= 32'd0;
      pkt_q      <= 32'd0;
      err_q      <= 16'd0;
      flag_q     <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ep_q       <= ep_d;
      stall_q    <= stall_d;
      expected_q <= expected_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
      flag_q     <= flag_d;
      tready_q   <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign beat_count    = beat_q;
  assign packet_count  = pkt_q;
  assign error_count   = err_q;
  assign error_flag    = flag_q;

endmodule

// File: tb/tb_axis_random_sink.sv
// Directed bench: one sink without stalls (pattern/counter/enable tests) and
// one with short stalls (backpressure bounds and reset determinism).
module tb_axis_random_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] exp_first = 32'd0;

  logic [31:0] td0 = 32'd0, td1 = 32'd0;
  logic        tv0 = 1'b0, tv1 = 1'b0, tl0 = 1'b0, tl1 = 1'b0;
  logic        rdy0, rdy1, ef0, ef1;
  logic [31:0] bc0, bc1, pc0, pc1;
  logic [15:0] ec0, ec1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axis_random_sink #(
    .DATA_WIDTH(32), .RAND_SEED(32'd3393937), .MAX_INTERRUPTIONS(0),
    .RX_MAX_DELAY_BETWEEN_TRANSACTIONS(42), .CHECK_PATTERN(1)
  ) u_nostall (
    .clk(clk), .rst(rst), .enable(enable), .expected_first(exp_first),
    .s_axis_tdata(td0), .s_axis_tvalid(tv0), .s_axis_tlast(tl0),
    .s_axis_tready(rdy0), .beat_count(bc0), .packet_count(pc0),
    .error_count(ec0), .error_flag(ef0)
  );

  axis_random_sink #(
    .DATA_WIDTH(32), .RAND_SEED(32'd3393937), .MAX_INTERRUPTIONS(3),
    .RX_MAX_DELAY_BETWEEN_TRANSACTIONS(4), .CHECK_PATTERN(1)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .expected_first(exp_first),
    .s_axis_tdata(td1), .s_axis_tvalid(tv1), .s_axis_tlast(tl1),
    .s_axis_tready(rdy1), .beat_count(bc1), .packet_count(pc1),
    .error_count(ec1), .error_flag(ef1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one beat (held from a negedge) and return at the negedge after it is taken.
  task automatic push(input int sel, input logic [31:0] d, input logic last, output int waits);
    waits = 0;
    if (sel == 0) begin td0 = d; tv0 = 1'b1; tl0 = last; end
    else          begin td1 = d; tv1 = 1'b1; tl1 = last; end
    while (((sel == 0) ? rdy0 : rdy1) == 1'b0 && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 64) chk("push_timeout", 32'((sel == 0) ? rdy0 : rdy1), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    tv0 = 1'b0; tv1 = 1'b0; tl0 = 1'b0; tl1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_traffic(input int npkts);
    int w;
    for (int p = 0; p < npkts; p++)
      for (int b = 0; b < 128; b++)
        push(1, 32'(p * 128 + b), (b == 127), w);
    tv1 = 1'b0; tl1 = 1'b0;
  endtask

  // tready history of the stalling sink, first 200 cycles after enable.
  logic         rec_en = 1'b0;
  int           rec_idx = 0;
  logic [199:0] hist_cur = '0;
  logic [199:0] hist_a = '0;

  always @(posedge clk) begin
    if (!rec_en) rec_idx <= 0;
    else if (rec_idx < 200) begin
      hist_cur[rec_idx] <= rdy1;
      rec_idx <= rec_idx + 1;
    end
  end

  // Stall-run monitor: run length 1..4, at most 3 runs per packet.
  logic mon_en = 1'b0;
  logic seen_hs = 1'b0;
  int   run_len = 0, runs_in_pkt = 0, runs_total = 0;

  always @(posedge clk) begin
    if (mon_en) begin
      if (tv1 && rdy1) seen_hs <= 1'b1;
      if (!rdy1 && seen_hs) begin
        if (run_len == 0) begin
          runs_in_pkt <= runs_in_pkt + 1;
          runs_total  <= runs_total + 1;
        end
        run_len <= run_len + 1;
      end else if (rdy1) begin
        if (run_len != 0) chk("t3_run_len_1to4", 32'(run_len >= 1 && run_len <= 4), 32'd1);
        run_len <= 0;
        if (tv1 && tl1) begin
          chk("t3_runs_per_pkt_le3", 32'(runs_in_pkt <= 3), 32'd1);
          runs_in_pkt <= 0;
        end
      end
    end else begin
      seen_hs     <= 1'b0;
      run_len     <= 0;
      runs_in_pkt <= 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, tw;
    logic [31:0] seq2 [6];
    bit found;
    seq2 = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd6, 32'd7};

    // T1: reset values, then an 8-beat packet with no stalls.
    exp_first = 32'd0;
    @(negedge clk);
    chk("rst_tready", 32'(rdy0), 32'd0);
    chk("rst_beats",  bc0, 32'd0);
    chk("rst_pkts",   pc0, 32'd0);
    chk("rst_errs",   32'(ec0), 32'd0);
    chk("rst_flag",   32'(ef0), 32'd0);
    do_reset();
    enable = 1'b1;
    tw = 0;
    for (int i = 0; i < 8; i++) begin
      push(0, 32'(i), (i == 7), w);
      if (i > 0) tw += w;
    end
    tv0 = 1'b0; tl0 = 1'b0;
    chk("t1_no_wait", 32'(tw), 32'd0);
    chk("t1_beats",   bc0, 32'd8);
    chk("t1_pkts",    pc0, 32'd1);
    chk("t1_errs",    32'(ec0), 32'd0);
    chk("t1_flag",    32'(ef0), 32'd0);

    // T2: one gap in the sequence gives exactly one error.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(0, seq2[i], (i == 5), w);
      if (i == 2) chk("t2_flag_before", 32'(ef0), 32'd0);
      if (i == 3) begin
        chk("t2_err_at5",  32'(ec0), 32'd1);
        chk("t2_flag_at5", 32'(ef0), 32'd1);
      end
    end
    tv0 = 1'b0; tl0 = 1'b0;
    chk("t2_err_final", 32'(ec0), 32'd1);
    chk("t2_beats",     bc0, 32'd6);
    chk("t2_pkts",      pc0, 32'd1);

    // T4: enable drop mid-packet; the beat in the falling cycle is still taken.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) push(0, 32'(i), 1'b0, w);
    td0 = 32'd3; tv0 = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk("t4_tready_low", 32'(rdy0), 32'd0);
    chk("t4_beats_drop", bc0, 32'd4);
    td0 = 32'd4;
    repeat (5) @(negedge clk);
    chk("t4_tready_held", 32'(rdy0), 32'd0);
    chk("t4_beats_frozen", bc0, 32'd4);
    exp_first = 32'd4; enable = 1'b1;
    push(0, 32'd4, 1'b0, w);
    push(0, 32'd5, 1'b0, w);
    push(0, 32'd6, 1'b1, w);
    tv0 = 1'b0; tl0 = 1'b0;
    chk("t4_errs",  32'(ec0), 32'd0);
    chk("t4_beats", bc0, 32'd7);
    chk("t4_pkts",  pc0, 32'd1);

    // T3: ten 128-beat packets through the stalling sink.
    exp_first = 32'd0;
    do_reset();
    enable = 1'b1; rec_en = 1'b1; mon_en = 1'b1;
    run_traffic(10);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    hist_a = hist_cur;
    chk("t3_beats", bc1, 32'd1280);
    chk("t3_pkts",  pc1, 32'd10);
    chk("t3_errs",  32'(ec1), 32'd0);
    chk("t3_stall_seen", 32'(runs_total > 0), 32'd1);

    // T5: reset while stalled, then the same traffic must stall identically.
    rec_en = 1'b0;
    do_reset();
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      push(1, 32'(k), 1'b0, w);
      if (!rdy1) found = 1'b1;
    end
    chk("t5_in_stall", 32'(rdy1), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_tready", 32'(rdy1), 32'd0);
    chk("t5_rst_beats",  bc1, 32'd0);
    chk("t5_rst_pkts",   pc1, 32'd0);
    chk("t5_rst_errs",   32'(ec1), 32'd0);
    chk("t5_rst_flag",   32'(ef1), 32'd0);
    do_reset();
    enable = 1'b1; rec_en = 1'b1;
    run_traffic(2);
    chk("t5_same_stalls", 32'(hist_cur == hist_a), 32'd1);
    chk("t5_beats", bc1, 32'd256);
    chk("t5_errs",  32'(ec1), 32'd0);
    rec_en = 1'b0;

    // T6: 65537 mismatching beats saturate the error counter.
    exp_first = 32'd1;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 65534; i++) push(0, 32'd0, 1'b0, w);
    chk("t6_err_fffe", 32'(ec0), 32'h0000_FFFE);
    push(0, 32'd0, 1'b0, w);
    chk("t6_err_ffff", 32'(ec0), 32'h0000_FFFF);
    push(0, 32'd0, 1'b0, w);
    push(0, 32'd0, 1'b0, w);
    tv0 = 1'b0;
    chk("t6_err_sat",   32'(ec0), 32'h0000_FFFF);
    chk("t6_beats",     bc0, 32'd65537);
    chk("t6_flag",      32'(ef0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
